// File: rtl/mul_hilo_pkg.sv
// Shared encodings for the HI/LO multiply controller: op codes, FSM states, capture modes.
// MUL_HILO_MADD_EN adds the MADD/MSUB family to the multiply-class decode.
package mul_hilo_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACC_LOAD = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_mode_e;

  function automatic logic op_is_mul(logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef MUL_HILO_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic acc_mode_e op_acc_mode(logic [3:0] op);
    case (op)
      OP_MADD, OP_MADDU: return ACC_ADD;
      OP_MSUB, OP_MSUBU: return ACC_SUB;
      default:           return ACC_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl_hilo_regs.sv
// HI/LO register pair: MTHI/MTLO writes and 64-bit product capture.
// The accumulate/subtract capture path exists only when MUL_HILO_MADD_EN is defined.
module hilo_regs
  import mul_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mthi_we_i,
  input  logic        mtlo_we_i,
  input  logic [31:0] wdata_i,
  input  logic        cap_en_i,
  input  logic [1:0]  cap_mode_i,
  input  logic [63:0] cap_data_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] cap_val;

`ifdef MUL_HILO_MADD_EN
  always_comb begin
    case (cap_mode_i)
      ACC_ADD: cap_val = {hi_q, lo_q} + cap_data_i;
      ACC_SUB: cap_val = {hi_q, lo_q} - cap_data_i;
      default: cap_val = cap_data_i;
    endcase
  end
`else
  // Only plain loads exist in this build, so the mode is irrelevant.
  logic unused_cap_mode;
  assign unused_cap_mode = ^cap_mode_i;
  assign cap_val = cap_data_i;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cap_en_i) begin
      {hi_d, lo_d} = cap_val;
    end else begin
      if (mthi_we_i) hi_d = wdata_i;
      if (mtlo_we_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multi-cycle multiply controller between EX and the array multiplier; owns HI/LO.
// Defining MUL_HILO_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
//
// state   | meaning
// IDLE    | accept multiply or MTHI/MTLO from EX
// CALC    | operands held on the multiplier, pipeline stalled
// DONE    | product in HI/LO, completing instruction leaves EX
module mul_hilo_ctrl
  import mul_hilo_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mul_start_o,
  output logic        mul_sign_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] CNT_LAST = 4'(MUL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        sign_q, sign_d;
  acc_mode_e   mode_q, mode_d;
  logic        mthi_we, mtlo_we, cap_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sign_d      = sign_q;
    mode_d      = mode_q;
    stall_o     = 1'b0;
    mul_start_o = 1'b0;
    mthi_we     = 1'b0;
    mtlo_we     = 1'b0;
    cap_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i) begin
          if (op_is_mul(op_i)) begin
            op1_d   = rs_i;
            op2_d   = rt_i;
            sign_d  = op_is_signed(op_i);
            mode_d  = op_acc_mode(op_i);
            cnt_d   = '0;
            stall_o = 1'b1;
            state_d = ST_CALC;
          end else if (op_i == OP_MTHI) begin
            mthi_we = 1'b1;
          end else if (op_i == OP_MTLO) begin
            mtlo_we = 1'b1;
          end
        end
      end
      ST_CALC: begin
        mul_start_o = 1'b1;
        stall_o     = 1'b1;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          cap_en  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flush kills whatever is in flight, including an accept in this same cycle.
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = cnt_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      sign_d  = sign_q;
      mode_d  = mode_q;
      stall_o = 1'b0;
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      cap_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sign_q  <= 1'b0;
      mode_q  <= ACC_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
    end
  end

  assign mul_op1_o  = op1_q;
  assign mul_op2_o  = op2_q;
  assign mul_sign_o = sign_q;

  hilo_regs u_hilo_regs (
    .clk        (clk),
    .resetn     (resetn),
    .mthi_we_i  (mthi_we),
    .mtlo_we_i  (mtlo_we),
    .wdata_i    (rs_i),
    .cap_en_i   (cap_en),
    .cap_mode_i (mode_q),
    .cap_data_i (mul_result_i),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: cycle model of the op timeline plus directed literals.
// Expectations follow MUL_HILO_MADD_EN when it is defined for the build.
module tb_mul_hilo_ctrl;

  localparam int MC = 2;
`ifdef MUL_HILO_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        ex_valid_i;
  logic [3:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        flush_i;
  logic        stall_o, mul_start_o, mul_sign_o;
  logic [31:0] mul_op1_o, mul_op2_o;
  logic [63:0] mul_result_i;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  mul_hilo_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ex_valid_i   (ex_valid_i),
    .op_i         (op_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .mul_start_o  (mul_start_o),
    .mul_sign_o   (mul_sign_o),
    .mul_op1_o    (mul_op1_o),
    .mul_op2_o    (mul_op2_o),
    .mul_result_i (mul_result_i),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Behavioural multiplier: product only while the controller enables it.
  assign mul_result_i = mul_start_o ? mul64(mul_op1_o, mul_op2_o, mul_sign_o) : 64'bx;

  function automatic bit is_mul_op(logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (MADD_EN && op >= 4'd5 && op <= 4'd8);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1..MC operands on the multiplier, MC+1 completion cycle.
  int          phase = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_op1 = '0, m_op2 = '0;
  logic        m_sign = 1'b0;
  int          m_mode = 0;
  logic [63:0] m_acc;

  always @(posedge clk) begin
    if (!resetn) begin
      phase = 0; m_hi = '0; m_lo = '0; m_op1 = '0; m_op2 = '0; m_sign = 1'b0; m_mode = 0;
    end else if (flush_i) begin
      phase = 0;
    end else if (phase == 0) begin
      if (ex_valid_i && is_mul_op(op_i)) begin
        m_op1  = rs_i;
        m_op2  = rt_i;
        m_sign = (op_i == 4'd1) || (op_i == 4'd5) || (op_i == 4'd7);
        m_mode = (op_i == 4'd5 || op_i == 4'd6) ? 1 : (op_i == 4'd7 || op_i == 4'd8) ? 2 : 0;
        phase  = 1;
      end else if (ex_valid_i && op_i == 4'd3) begin
        m_hi = rs_i;
      end else if (ex_valid_i && op_i == 4'd4) begin
        m_lo = rs_i;
      end
    end else if (phase <= MC) begin
      if (phase == MC) begin
        m_acc = {m_hi, m_lo};
        case (m_mode)
          1:       m_acc = m_acc + mul64(m_op1, m_op2, m_sign);
          2:       m_acc = m_acc - mul64(m_op1, m_op2, m_sign);
          default: m_acc = mul64(m_op1, m_op2, m_sign);
        endcase
        {m_hi, m_lo} = m_acc;
      end
      phase++;
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit in_calc, exp_stall;
      in_calc   = (phase >= 1) && (phase <= MC);
      exp_stall = !flush_i && (in_calc || (phase == 0 && ex_valid_i && is_mul_op(op_i)));
      check("stall_o",     64'(stall_o),     64'(exp_stall));
      check("mul_start_o", 64'(mul_start_o), 64'(in_calc));
      check("mul_sign_o",  64'(mul_sign_o),  64'(m_sign));
      check("mul_op1_o",   64'(mul_op1_o),   64'(m_op1));
      check("mul_op2_o",   64'(mul_op2_o),   64'(m_op2));
      check("hi_o",        64'(hi_o),        64'(m_hi));
      check("lo_o",        64'(lo_o),        64'(m_lo));
    end
  end

  // Holds the instruction in EX until it leaves (stall_o low at an edge); returns stall cycles.
  task automatic do_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int nstall);
    bit s, left;
    nstall = 0;
    left = 1'b0;
    ex_valid_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s = stall_o;
      if (s) nstall++;
      @(posedge clk);
      if (!s) begin
        left = 1'b1;
        break;
      end
    end
    if (!left) begin
      tests++;
      fails++;
      $display("FAIL do_op_timeout: op %0d still stalled after 40 cycles, required release", op);
    end
    #1;
    ex_valid_i = 1'b0; op_i = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    resetn = 1'b0; ex_valid_i = 1'b0; op_i = 4'd0; rs_i = '0; rt_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    check("rst_hi", 64'(hi_o), 64'h0);
    check("rst_lo", 64'(lo_o), 64'h0);
    check("rst_stall", 64'(stall_o), 64'h0);
    check("rst_start", 64'(mul_start_o), 64'h0);
    idle(1);

    // 1: signed multiply
    do_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, n);
    check("t1_stall_cycles", 64'(n), 64'd3);
    check("t1_hi", 64'(hi_o), 64'hFFFF_FFFF);
    check("t1_lo", 64'(lo_o), 64'hFFFF_FFFE);
    check("t1_sign", 64'(mul_sign_o), 64'd1);
    idle(1);

    // 2: unsigned multiply
    do_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, n);
    check("t2_stall_cycles", 64'(n), 64'd3);
    check("t2_hi", 64'(hi_o), 64'h0000_0001);
    check("t2_lo", 64'(lo_o), 64'hFFFF_FFFE);
    check("t2_sign", 64'(mul_sign_o), 64'd0);

    // 3: moves then MADD
    do_op(4'd3, 32'h0, 32'h0, n);
    check("t3_mthi_stall", 64'(n), 64'd0);
    do_op(4'd4, 32'h5, 32'h0, n);
    check("t3_mtlo_stall", 64'(n), 64'd0);
    check("t3_mtlo_lo", 64'(lo_o), 64'h5);
    do_op(4'd5, 32'h3, 32'hFFFF_FFFF, n);
    check("t3_madd_stall", 64'(n), MADD_EN ? 64'd3 : 64'd0);
    check("t3_hi", 64'(hi_o), 64'h0);
    check("t3_lo", 64'(lo_o), MADD_EN ? 64'h2 : 64'h5);

    // 4: MSUBU wrap
    do_op(4'd3, 32'h0, 32'h0, n);
    do_op(4'd4, 32'h0, 32'h0, n);
    do_op(4'd8, 32'h1, 32'h1, n);
    check("t4_msubu_stall", 64'(n), MADD_EN ? 64'd3 : 64'd0);
    check("t4_hi", 64'(hi_o), MADD_EN ? 64'hFFFF_FFFF : 64'h0);
    check("t4_lo", 64'(lo_o), MADD_EN ? 64'hFFFF_FFFF : 64'h0);

    // 5: flush in the second CALC cycle
    do_op(4'd3, 32'h1111_1111, 32'h0, n);
    do_op(4'd4, 32'h2222_2222, 32'h0, n);
    ex_valid_i = 1'b1; op_i = 4'd1; rs_i = 32'h2; rt_i = 32'h2;
    idle(1);
    idle(1);
    flush_i = 1'b1;
    @(negedge clk);
    check("t5_flush_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0; ex_valid_i = 1'b0; op_i = 4'd0;
    check("t5_idle_start", 64'(mul_start_o), 64'd0);
    check("t5_idle_stall", 64'(stall_o), 64'd0);
    idle(3);
    check("t5_hi", 64'(hi_o), 64'h1111_1111);
    check("t5_lo", 64'(lo_o), 64'h2222_2222);

    // 6: reset mid-CALC, then back-to-back multiplies
    ex_valid_i = 1'b1; op_i = 4'd1; rs_i = 32'h3; rt_i = 32'h3;
    idle(1);
    resetn = 1'b0; ex_valid_i = 1'b0; op_i = 4'd0;
    idle(1);
    check("t6_rst_hi", 64'(hi_o), 64'h0);
    check("t6_rst_lo", 64'(lo_o), 64'h0);
    check("t6_rst_op1", 64'(mul_op1_o), 64'h0);
    check("t6_rst_op2", 64'(mul_op2_o), 64'h0);
    check("t6_rst_sign", 64'(mul_sign_o), 64'h0);
    check("t6_rst_start", 64'(mul_start_o), 64'h0);
    check("t6_rst_stall", 64'(stall_o), 64'h0);
    resetn = 1'b1;
    idle(1);
    do_op(4'd1, 32'd5, 32'd7, n);
    check("t6_first_stall", 64'(n), 64'd3);
    check("t6_first_lo", 64'(lo_o), 64'd35);
    check("t6_first_hi", 64'(hi_o), 64'd0);
    do_op(4'd1, 32'd6, 32'd6, n);
    check("t6_second_stall", 64'(n), 64'd3);
    check("t6_second_lo", 64'(lo_o), 64'd36);
    idle(4);
    check("t6_final_lo", 64'(lo_o), 64'd36);
    check("t6_final_start", 64'(mul_start_o), 64'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_hilo_ctrl.md
# mul_hilo_ctrl

Multi-cycle controller that sits between the EX stage and the combinational array multiplier, and owns the HI/LO register pair. It accepts multiply and HI/LO-move operations from EX and drives the multiplier's operands, sign and start. It holds those inputs stable for a fixed number of cycles while stalling the pipeline, then captures the 64-bit product into HI/LO.

## Interface
Parameters:
- MUL_CYCLES, default 2: cycles the multiplier inputs are held before the product is captured; legal range 1–15.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset; the only clock is clk
- ex_valid_i  in  1  valid instruction in EX
- op_i  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU; any other code is NOP
- rs_i  in  32  operand 1, and the MTHI/MTLO source
- rt_i  in  32  operand 2
- flush_i  in  1  pipeline flush; aborts the current operation
- stall_o  out  1  pipeline stall request
- mul_start_o  out  1  multiplier enable
- mul_sign_o  out  1  signed multiply
- mul_op1_o  out  32  latched operand 1
- mul_op2_o  out  32  latched operand 2
- mul_result_i  in  64  multiplier product
- hi_o  out  32  HI register
- lo_o  out  32  LO register

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**, when ex_valid_i is high and op_i is a multiply class op:
  - latch rs_i/rt_i into mul_op1_o/mul_op2_o;
  - latch signedness (MULT, MADD, MSUB are signed) and the accumulate mode;
  - clear cnt and go to CALC;
  - stall_o=1 combinationally.
- **IDLE**, MTHI/MTLO with ex_valid_i high: write rs_i to HI or LO at the clock edge. No stall, no state change.
- **CALC**:
  - mul_start_o=1 and stall_o=1; cnt increments each cycle.
  - When cnt==MUL_CYCLES-1, write the capture value to {HI,LO} at the edge and go to DONE.
- **Capture value**:
  - MULT/MULTU: mul_result_i.
  - MADD/MADDU: {HI,LO}+mul_result_i.
  - MSUB/MSUBU: {HI,LO}-mul_result_i.
  - Arithmetic is 64-bit, modulo 2^64; there is no overflow flag.
- **DONE**: stall_o=0 and mul_start_o=0; the completing instruction leaves EX. ex_valid_i/op_i are ignored here so the op does not re-trigger. Go to IDLE.
- **flush_i** has the highest priority after reset. In any state it forces IDLE, with no HI/LO write and no MTHI/MTLO write, and stall_o=0 in that cycle.
- **Reset values**: state IDLE, cnt 0, hi_o=lo_o=0, mul_op1_o=mul_op2_o=0, mul_sign_o=0, mul_start_o=0, stall_o=0.
- Reset asserted mid-CALC discards the operation; HI/LO return to 0.

## Timing
- Accept cycle T: stall_o=1.
- Cycles T+1..T+MUL_CYCLES: CALC, mul_start_o=1.
- HI/LO update at the edge ending T+MUL_CYCLES.
- T+MUL_CYCLES+1: DONE, stall_o=0, new HI/LO visible.
- Total stall: MUL_CYCLES+1 cycles.
- Back-to-back multiplies: the second is accepted in the IDLE cycle after DONE at the earliest.
- An MTHI/MTLO write is visible on hi_o/lo_o the cycle after acceptance.
- mul_op*_o and mul_sign_o are registered outputs and stay stable through CALC.
- stall_o is combinational from ex_valid_i/op_i only in IDLE.

## Configuration
- MUL_HILO_MADD_EN defined: ops 5–8 accumulate into or subtract from {HI,LO} as described.
- MUL_HILO_MADD_EN undefined: ops 5–8 decode as NOP. No stall, no write, and no 64-bit adder/subtractor is built; capture is a plain load.

## Structure
- Package mul_hilo_pkg holds:
  - op_i encodings as localparams;
  - the state encoding (IDLE/CALC/DONE);
  - the accumulate-mode encoding (LOAD/ADD/SUB).
- Sub-module hilo_regs holds the HI/LO storage. Its inputs are a reset, MTHI/MTLO write enables, a 64-bit capture enable and a capture mode. It contains the 64-bit accumulate/subtract path under MUL_HILO_MADD_EN.
- The FSM, counter and operand latches stay in mul_hilo_ctrl.
- The bench models the multiplier as a behavioural product, with X driven on mul_result_i when mul_start_o=0.

## Test plan
1. **Signed multiply.** MUL_CYCLES=2, MULT rs=0xFFFFFFFF, rt=0x00000002.
   - Expect stall_o high for 3 cycles, mul_sign_o=1.
   - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
2. **Unsigned multiply.** MULTU, same operands -> HI=0x00000001, LO=0xFFFFFFFE, mul_sign_o=0.
3. **Moves and MADD.** MTHI 0, MTLO 5 (no stall), then MADD rs=3, rt=0xFFFFFFFF -> HI=0x00000000, LO=0x00000002.
4. **MSUBU wrap.** HI=LO=0, MSUBU 1×1 -> HI=LO=0xFFFFFFFF.
   - Repeat without MUL_HILO_MADD_EN -> no stall, HI=LO=0.
5. **Flush mid-CALC.** HI=0x11111111, LO=0x22222222, MULT 2×2, flush_i in the second CALC cycle.
   - Expect stall_o=0 that cycle, IDLE next, HI/LO unchanged.
6. **Reset and back-to-back.**
   - resetn low in CALC -> all outputs at reset values the next cycle.
   - Two back-to-back MULTs (5×7, then 6×6) -> LO=35, then LO=36.
   - The second is accepted only after DONE, and DONE does not re-trigger the first op.
